// File: rtl/key_conditioner.sv
// Board button/switch front end for the radix-4 multiplier: synchronizes and debounces KEY,
// turns presses into one-clock commands, and locks out operand/start while a multiply runs.
module key_conditioner #(
    parameter int unsigned DB_COUNT = 500000,
    parameter int unsigned CNT_W    = 19,
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned TO_W     = 10
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] key_i,
    input  logic [7:0] sw_i,
    input  logic       done_i,
    output logic       start_o,
    output logic       get_a_o,
    output logic       get_b_o,
    output logic       put_out_o,
    output logic [7:0] in_o,
    output logic       busy_o
);

    localparam logic [CNT_W-1:0] DbLast = CNT_W'(DB_COUNT - 1);
    localparam logic [TO_W-1:0]  ToLast = TO_W'(TIMEOUT - 1);

    typedef enum logic {StIdle, StRun} state_e;

    logic [3:0]            key_s1_q, key_s2_q;
    logic [3:0]            stable_q, stable_d;
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]            press_d, p_q;
    logic [7:0]            sw_s1_q, sw_s2_q;
    logic [7:0]            in_q;
    logic [TO_W-1:0]       to_cnt_q;
    logic                  done_q;
    logic                  done_rise;
    state_e                state_q;

    // Any sample that matches the accepted level restarts the count, so bounce is absorbed.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (key_s2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DbLast) begin
                stable_d[i] = key_s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        press_d = stable_q & ~stable_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_s1_q <= '1;
            key_s2_q <= '1;
            stable_q <= '1;
            cnt_q    <= '0;
            p_q      <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            key_s1_q <= key_i;
            key_s2_q <= key_s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            p_q      <= press_d;
            sw_s1_q  <= sw_i;
            sw_s2_q  <= sw_s1_q;
        end
    end

    assign done_rise = done_i & ~done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            to_cnt_q <= '0;
            done_q   <= 1'b0;
            in_q     <= '0;
        end else begin
            done_q <= done_i;
            case (state_q)
                StIdle: begin
                    in_q <= sw_s2_q;
                    if (p_q[0]) begin
                        state_q  <= StRun;
                        to_cnt_q <= '0;
                    end
                end
                StRun: begin
                    if (done_rise || (to_cnt_q == ToLast)) begin
                        state_q <= StIdle;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Commands issued during RUN are dropped, not queued.
    assign start_o   = p_q[0] & (state_q == StIdle);
    assign get_a_o   = p_q[1] & (state_q == StIdle);
    assign get_b_o   = p_q[2] & (state_q == StIdle);
    assign put_out_o = p_q[3];
    assign busy_o    = (state_q == StRun);
    assign in_o      = in_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: vector table for debounce/sync, sequences for lockout,
// timeout, putOut passthrough and asynchronous reset.
module tb_key_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] key;
    logic [7:0] sw;
    logic       done;
    logic       start, get_a, get_b, put_out, busy;
    logic [7:0] in_v;
    logic [3:0] pulses;

    key_conditioner #(
        .DB_COUNT(4),
        .CNT_W   (3),
        .TIMEOUT (16),
        .TO_W    (4)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .key_i    (key),
        .sw_i     (sw),
        .done_i   (done),
        .start_o  (start),
        .get_a_o  (get_a),
        .get_b_o  (get_b),
        .put_out_o(put_out),
        .in_o     (in_v),
        .busy_o   (busy)
    );

    assign pulses = {put_out, get_b, get_a, start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] key;
        logic [7:0] sw;
        logic [3:0] exp_pulse;
        logic       exp_busy;
        logic [7:0] exp_in;
    } vec_t;

    vec_t tbl [64];
    int   n_rows   = 0;
    int   checks   = 0;
    int   failures = 0;

    task automatic add_rows(input int cnt, input logic [3:0] k, input logic [7:0] s,
                            input logic [3:0] ep, input logic [7:0] ei);
        for (int i = 0; i < cnt; i++) begin
            tbl[n_rows] = '{key: k, sw: s, exp_pulse: ep, exp_busy: 1'b0, exp_in: ei};
            n_rows++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds key[k] low for `hold` edges; a press must surface on the 6th edge (index 5).
    task automatic press(input int k, input int hold, input logic exp_pulse, input string name);
        int hits, at, others;
        hits = 0; at = -1; others = 0;
        key[k] = 1'b0;
        for (int t = 0; t < hold; t++) begin
            tick();
            if (pulses[k]) begin
                hits++;
                at = t;
            end
            if ((pulses & ~(4'b0001 << k)) != 4'b0000) others++;
        end
        key[k] = 1'b1;
        check({name, "_count"}, hits, exp_pulse ? 1 : 0);
        if (exp_pulse) check({name, "_cycle"}, at, 5);
        check({name, "_others"}, others, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc, hits, at, others;
        rst_n = 1'b0;
        key   = 4'hF;
        sw    = 8'h00;
        done  = 1'b0;

        add_rows(2,  4'hF, 8'h00, 4'b0000, 8'h00);
        add_rows(5,  4'hD, 8'h00, 4'b0000, 8'h00);
        add_rows(1,  4'hD, 8'h00, 4'b0010, 8'h00);
        add_rows(4,  4'hD, 8'h00, 4'b0000, 8'h00);
        add_rows(10, 4'hF, 8'h00, 4'b0000, 8'h00);
        add_rows(3,  4'hB, 8'h00, 4'b0000, 8'h00);
        add_rows(1,  4'hF, 8'h00, 4'b0000, 8'h00);
        add_rows(5,  4'hB, 8'h00, 4'b0000, 8'h00);
        add_rows(1,  4'hB, 8'h00, 4'b0100, 8'h00);
        add_rows(4,  4'hB, 8'h00, 4'b0000, 8'h00);
        add_rows(2,  4'hF, 8'h5A, 4'b0000, 8'h00);
        add_rows(6,  4'hF, 8'h5A, 4'b0000, 8'h5A);

        #12;
        check("reset_pulses", int'(pulses), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_in", int'(in_v), 0);
        rst_n = 1'b1;

        for (int i = 0; i < n_rows; i++) begin
            key = tbl[i].key;
            sw  = tbl[i].sw;
            tick();
            check($sformatf("vec%0d{pulse,busy,in}", i), int'({pulses, busy, in_v}),
                  int'({tbl[i].exp_pulse, tbl[i].exp_busy, tbl[i].exp_in}));
        end

        // Lockout
        sw = 8'hA5;
        repeat (3) tick();
        check("t3_in_idle", int'(in_v), 8'hA5);
        press(0, 7, 1'b1, "t3_start");
        check("t3_busy", int'(busy), 1);
        sw = 8'h3C;
        press(1, 7, 1'b0, "t3_geta_locked");
        check("t3_busy_hold", int'(busy), 1);
        check("t3_in_hold", int'(in_v), 8'hA5);
        done = 1'b1;
        tick();
        check("t3_done_busy", int'(busy), 0);
        check("t3_in_before_load", int'(in_v), 8'hA5);
        tick();
        check("t3_in_reload", int'(in_v), 8'h3C);
        done = 1'b0;
        tick();

        // Timeout
        press(0, 7, 1'b1, "t4_start");
        bc = busy ? 1 : 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (!busy) break;
            bc++;
        end
        check("t4_busy_cycles", bc, 16);
        press(0, 7, 1'b1, "t4_restart");
        check("t4_busy_again", int'(busy), 1);

        // putOut passes through while busy
        press(3, 7, 1'b1, "t5_putout");
        check("t5_busy", int'(busy), 1);

        // Asynchronous reset mid-debounce and mid-RUN
        key[1] = 1'b0;
        repeat (3) tick();
        check("t6_busy_pre", int'(busy), 1);
        check("t6_in_pre", int'(in_v), 8'h3C);
        #2 rst_n = 1'b0;
        #1;
        check("t6_reset_busy", int'(busy), 0);
        check("t6_reset_in", int'(in_v), 0);
        check("t6_reset_pulses", int'(pulses), 0);
        #3 rst_n = 1'b1;
        hits = 0; at = -1; others = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (get_a) begin
                hits++;
                at = t;
            end
            if ((pulses & 4'b1101) != 4'b0000 || busy) others++;
        end
        key[1] = 1'b1;
        check("t6_geta_count", hits, 1);
        check("t6_geta_cycle", at, 5);
        check("t6_others", others, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
